// File: rtl/vrf_read_sequencer_if.sv
// Operand-read handshake between vector dispatch, the read sequencer and the
// banked VRF read port. Master is the environment side, slave is the sequencer.
interface vrf_read_sequencer_if #(
  parameter int RPORT_NUM       = 3,
  parameter int VREG_ADDR_WIDTH = 6,
  parameter int FIELD_WIDTH     = 4,
  parameter int TAG_WIDTH       = 2
);
  logic                                 flush;
  logic                                 req_vld;
  logic                                 req_rdy;
  logic [RPORT_NUM-1:0]                 req_rs_vld;
  logic [RPORT_NUM*5-1:0]               req_rs_vreg;
  logic [RPORT_NUM*TAG_WIDTH-1:0]       req_rs_tag;
  logic [1:0]                           req_lmul;
  logic                                 vrf_busy;
  logic [RPORT_NUM-1:0]                 rd_vld;
  logic [RPORT_NUM*VREG_ADDR_WIDTH-1:0] rd_vaddr;
  logic [RPORT_NUM*TAG_WIDTH-1:0]       rd_rs_idx;
  logic [RPORT_NUM*FIELD_WIDTH-1:0]     rd_field_idx;
  logic                                 seq_done;

  modport master (
    output flush, req_vld, req_rs_vld, req_rs_vreg, req_rs_tag, req_lmul, vrf_busy,
    input  req_rdy, rd_vld, rd_vaddr, rd_rs_idx, rd_field_idx, seq_done
  );

  modport slave (
    input  flush, req_vld, req_rs_vld, req_rs_vreg, req_rs_tag, req_lmul, vrf_busy,
    output req_rdy, rd_vld, rd_vaddr, rd_rs_idx, rd_field_idx, seq_done
  );
endinterface

// File: rtl/vrf_read_sequencer.sv
// Expands one multi-operand vector read request into SEG_NUM<<lmul segment
// beats, holding each packet until the register file accepts it.
module vrf_read_sequencer #(
  parameter int RPORT_NUM       = 3,
  parameter int ISA_VREG_NUM    = 32,
  parameter int SEG_NUM         = 2,
  parameter int VREG_ADDR_WIDTH = 6,
  parameter int FIELD_WIDTH     = 4,
  parameter int TAG_WIDTH       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  vrf_read_sequencer_if.slave   bus
);

  localparam int VREG_W = $clog2(ISA_VREG_NUM);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                                 state_q, state_d;
  logic [FIELD_WIDTH-1:0]                 beat_q, beat_d;
  logic [RPORT_NUM-1:0]                   vld_q, vld_d;
  logic [RPORT_NUM-1:0][VREG_W-1:0]       base_q, base_d;
  logic [RPORT_NUM-1:0][TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [1:0]                             lmul_q, lmul_d;
  logic                                   done_q, done_d;

  logic [FIELD_WIDTH-1:0] last_beat;
  logic                   is_last;
  logic                   rdy;
  logic                   accept;
  logic                   load;

  always_comb begin
    last_beat = FIELD_WIDTH'((SEG_NUM << lmul_q) - 1);
    is_last   = (beat_q == last_beat);
    rdy       = ~rst & ~bus.flush &
                ((state_q == IDLE) | ((state_q == ISSUE) & is_last & ~bus.vrf_busy));
    accept    = bus.req_vld & rdy;
    bus.req_rdy = rdy;
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    vld_d   = vld_q;
    base_d  = base_q;
    tag_d   = tag_q;
    lmul_d  = lmul_q;
    done_d  = 1'b0;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (|bus.req_rs_vld) load   = 1'b1;
          else                 done_d = 1'b1;
        end
      end
      ISSUE: begin
        if (bus.flush) begin
          state_d = IDLE;
          beat_d  = '0;
        end else if (!bus.vrf_busy) begin
          if (!is_last) begin
            beat_d = beat_q + 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
            beat_d  = '0;
            // A request taken on the final beat restarts the sequence without a bubble.
            if (accept && (|bus.req_rs_vld)) load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = ISSUE;
      beat_d  = '0;
      vld_d   = bus.req_rs_vld;
      lmul_d  = bus.req_lmul;
      for (int unsigned i = 0; i < RPORT_NUM; i++) begin
        base_d[i] = bus.req_rs_vreg[i*5 +: VREG_W] & ~VREG_W'((1 << bus.req_lmul) - 1);
        tag_d[i]  = bus.req_rs_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      vld_q   <= '0;
      base_q  <= '0;
      tag_q   <= '0;
      lmul_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      vld_q   <= vld_d;
      base_q  <= base_d;
      tag_q   <= tag_d;
      lmul_q  <= lmul_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    bus.rd_vld       = '0;
    bus.rd_vaddr     = '0;
    bus.rd_rs_idx    = '0;
    bus.rd_field_idx = '0;
    bus.seq_done     = done_q;
    for (int unsigned i = 0; i < RPORT_NUM; i++) begin
      if ((state_q == ISSUE) && vld_q[i]) begin
        bus.rd_vld[i] = 1'b1;
        bus.rd_vaddr[i*VREG_ADDR_WIDTH +: VREG_ADDR_WIDTH] =
          VREG_ADDR_WIDTH'(base_q[i] * SEG_NUM) + VREG_ADDR_WIDTH'(beat_q);
        bus.rd_rs_idx[i*TAG_WIDTH +: TAG_WIDTH]          = tag_q[i];
        bus.rd_field_idx[i*FIELD_WIDTH +: FIELD_WIDTH]   = beat_q;
      end
    end
  end

endmodule

// File: tb/tb_vrf_read_sequencer.sv
// Randomized bench for vrf_read_sequencer against a beat-counting reference model.
module tb_vrf_read_sequencer;
  localparam int RPORT_NUM = 3;
  localparam int SEG_NUM   = 2;
  localparam int VAW       = 6;
  localparam int FW        = 4;
  localparam int TW        = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vrf_read_sequencer_if #(.RPORT_NUM(RPORT_NUM), .VREG_ADDR_WIDTH(VAW),
                          .FIELD_WIDTH(FW), .TAG_WIDTH(TW)) bus();

  vrf_read_sequencer #(.RPORT_NUM(RPORT_NUM), .ISA_VREG_NUM(32), .SEG_NUM(SEG_NUM),
                       .VREG_ADDR_WIDTH(VAW), .FIELD_WIDTH(FW), .TAG_WIDTH(TW))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  // reference model state
  bit         m_active = 0;
  bit         m_done   = 0;
  logic [2:0] m_vld    = '0;
  int         m_base[RPORT_NUM];
  int         m_tag[RPORT_NUM];
  int         m_lmul   = 0;
  int         m_beat   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_active = 0; m_done = 0; m_vld = '0; m_lmul = 0; m_beat = 0;
    for (int i = 0; i < RPORT_NUM; i++) begin m_base[i] = 0; m_tag[i] = 0; end
  endtask

  task automatic step(input logic rv, input logic [2:0] rsv, input logic [14:0] vreg,
                      input logic [5:0] tag, input logic [1:0] lmul,
                      input logic busy, input logic fl);
    int   last;
    int   v;
    bit   exp_rdy, acc, n_done;
    @(negedge clk);
    bus.req_vld     = rv;
    bus.req_rs_vld  = rsv;
    bus.req_rs_vreg = vreg;
    bus.req_rs_tag  = tag;
    bus.req_lmul    = lmul;
    bus.vrf_busy    = busy;
    bus.flush       = fl;
    #1;
    last = (SEG_NUM << m_lmul) - 1;
    check("rd_vld", 32'(bus.rd_vld), m_active ? 32'(m_vld) : 32'd0);
    check("seq_done", 32'(bus.seq_done), 32'(m_done));
    exp_rdy = !fl && (!m_active || (m_beat == last && !busy));
    check("req_rdy", 32'(bus.req_rdy), 32'(exp_rdy));
    if (m_active) begin
      for (int i = 0; i < RPORT_NUM; i++) begin
        if (m_vld[i]) begin
          check("rd_vaddr", 32'(bus.rd_vaddr[i*VAW +: VAW]), 32'((m_base[i]*SEG_NUM + m_beat) % 64));
          check("rd_field_idx", 32'(bus.rd_field_idx[i*FW +: FW]), 32'(m_beat));
          check("rd_rs_idx", 32'(bus.rd_rs_idx[i*TW +: TW]), 32'(m_tag[i]));
        end
      end
    end
    acc = rv && exp_rdy;
    @(posedge clk);
    n_done = 0;
    if (fl) begin
      m_active = 0; m_beat = 0;
    end else if (m_active && !busy) begin
      if (m_beat < last) m_beat++;
      else begin n_done = 1; m_active = 0; m_beat = 0; end
    end
    if (acc) begin
      if (rsv != 0) begin
        m_active = 1; m_beat = 0; m_vld = rsv; m_lmul = int'(lmul);
        for (int i = 0; i < RPORT_NUM; i++) begin
          v = int'(vreg[i*5 +: 5]);
          m_base[i] = v - (v % (1 << lmul));
          m_tag[i]  = int'(tag[i*2 +: 2]);
        end
      end else n_done = 1;
    end
    m_done = n_done;
  endtask

  task automatic idle(input logic busy);
    step(1'b0, 3'b000, 15'd0, 6'd0, 2'd0, busy, 1'b0);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    bus.req_vld = 1'b0; bus.flush = 1'b0; bus.vrf_busy = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_rd_vld", 32'(bus.rd_vld), 32'd0);
    check("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
    check("rst_seq_done", 32'(bus.seq_done), 32'd0);
    check("rst_rd_vaddr", 32'(bus.rd_vaddr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    model_clear();
    rst = 1'b1;
    bus.req_vld = 1'b0; bus.req_rs_vld = '0; bus.req_rs_vreg = '0; bus.req_rs_tag = '0;
    bus.req_lmul = '0; bus.vrf_busy = 1'b0; bus.flush = 1'b0;
    #1;
    check("reset_rd_vld", 32'(bus.rd_vld), 32'd0);
    check("reset_req_rdy", 32'(bus.req_rdy), 32'd0);
    check("reset_seq_done", 32'(bus.seq_done), 32'd0);
    check("reset_rd_field_idx", 32'(bus.rd_field_idx), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // LMUL=1, ports 0/1 at vregs 4/7
    step(1'b1, 3'b011, {5'd0, 5'd7, 5'd4}, {2'd0, 2'd2, 2'd1}, 2'd0, 1'b0, 1'b0);
    repeat (4) idle(1'b0);

    // LMUL=4, misaligned base 9, busy stall at beat 2
    step(1'b1, 3'b001, {5'd0, 5'd0, 5'd9}, 6'd3, 2'd2, 1'b0, 1'b0);
    repeat (2) idle(1'b0);
    repeat (3) idle(1'b1);
    repeat (8) idle(1'b0);

    // back-to-back on the last beat
    step(1'b1, 3'b111, {5'd30, 5'd2, 5'd5}, {2'd3, 2'd2, 2'd1}, 2'd0, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b1, 3'b101, {5'd31, 5'd0, 5'd12}, {2'd1, 2'd0, 2'd2}, 2'd1, 1'b0, 1'b0);
    repeat (6) idle(1'b0);

    // flush at beat 1 with a competing request
    step(1'b1, 3'b010, {5'd0, 5'd6, 5'd0}, 6'd8, 2'd1, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b1, 3'b001, {5'd0, 5'd0, 5'd3}, 6'd1, 2'd0, 1'b0, 1'b1);
    repeat (3) idle(1'b0);

    // empty request
    step(1'b1, 3'b000, 15'd0, 6'd0, 2'd3, 1'b0, 1'b0);
    repeat (2) idle(1'b0);

    // reset mid-sequence, then a fresh request
    step(1'b1, 3'b110, {5'd24, 5'd16, 5'd0}, 6'd0, 2'd3, 1'b0, 1'b0);
    repeat (3) idle(1'b0);
    reset_mid();
    step(1'b1, 3'b001, {5'd0, 5'd0, 5'd1}, 6'd2, 2'd0, 1'b0, 1'b0);
    repeat (3) idle(1'b0);

    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? 3'b000 : 3'($urandom_range(1, 7)),
           15'($urandom), 6'($urandom), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 31) == 0));
    end
    repeat (20) idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
